sar_magnitude_search: RTL and testbench

- Successive-approximation search engine that sits on the initiator side of our 4-bit magnitude comparator.
- It drives a guess onto the comparator's B operand and reads back less/equal/greater, where A is the unknown target.
- It resolves the target one bit per cycle, MSB first, and reports the value plus an equality-confirmed flag.
- Used wherever a value is observable only through a comparator, e.g. threshold discovery.

---
 rtl/sar_magnitude_search_if.sv | 26 ++
 rtl/sar_magnitude_search.sv | 125 ++++++++++++
 tb/tb_sar_magnitude_search.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sar_magnitude_search_if.sv
// Handshake/comparator bundle for sar_magnitude_search: the search engine is the
// master (drives guess, reads the comparator flags); the environment is the slave.
interface sar_magnitude_search_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic             cmp_less;
    logic             cmp_equal;
    logic             cmp_greater;
    logic [WIDTH-1:0] guess;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             found;
    logic             err;

    modport master (
        input  start, cmp_less, cmp_equal, cmp_greater,
        output guess, busy, done, result, found, err
    );

    modport slave (
        output start, cmp_less, cmp_equal, cmp_greater,
        input  guess, busy, done, result, found, err
    );
endinterface

// File: rtl/sar_magnitude_search.sv
// Successive-approximation search of a target visible only through a magnitude comparator.
// Optional macro CMP_ONEHOT_CHECK_EN: abort with err=1 on non-one-hot comparator flags.
module sar_magnitude_search #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    sar_magnitude_search_if.master bus
);
    localparam int unsigned IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        VERIFY
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             found_q, found_d;
    logic             err_q, err_d;
    logic             cmp_bad;

`ifdef CMP_ONEHOT_CHECK_EN
    assign cmp_bad = !$onehot({bus.cmp_less, bus.cmp_equal, bus.cmp_greater});
`else
    assign cmp_bad = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        guess_d  = guess_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        found_d  = found_q;
        err_d    = err_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    guess_d          = '0;
                    guess_d[WIDTH-1] = 1'b1;
                    idx_d            = IW'(WIDTH - 1);
                    busy_d           = 1'b1;
                    state_d          = SEARCH;
                end
            end
            SEARCH: begin
                if (cmp_bad) begin
                    result_d = guess_q;
                    found_d  = 1'b0;
                    err_d    = 1'b1;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else if (bus.cmp_equal) begin
                    result_d = guess_q;
                    found_d  = 1'b1;
                    err_d    = 1'b0;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else begin
                    // Greater is the fall-through, so an all-zero flag set keeps the bit.
                    if (bus.cmp_less) begin
                        guess_d[idx_q] = 1'b0;
                    end
                    if (idx_q != '0) begin
                        guess_d[idx_q - IW'(1)] = 1'b1;
                        idx_d                   = idx_q - IW'(1);
                    end else begin
                        state_d = VERIFY;
                    end
                end
            end
            VERIFY: begin
                result_d = guess_q;
                found_d  = bus.cmp_equal && !cmp_bad;
                err_d    = cmp_bad;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            guess_q  <= '0;
            idx_q    <= IW'(WIDTH - 1);
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            guess_q  <= guess_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            found_q  <= found_d;
            err_q    <= err_d;
        end
    end

    assign bus.guess  = guess_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.found  = found_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_sar_magnitude_search.sv
// Directed bench for sar_magnitude_search with a behavioural 4-bit comparator model.
module tb_sar_magnitude_search;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] target = 4'd0;
    logic force_both = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sar_magnitude_search_if #(.WIDTH(4)) bus ();

    sar_magnitude_search #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always_comb begin
        if (force_both) begin
            bus.cmp_less    = 1'b1;
            bus.cmp_equal   = 1'b0;
            bus.cmp_greater = 1'b1;
        end else begin
            bus.cmp_less    = target < bus.guess;
            bus.cmp_equal   = target == bus.guess;
            bus.cmp_greater = target > bus.guess;
        end
    end

    typedef struct {
        logic [3:0]  tgt;
        logic [19:0] seq;
        int          cycles;
        logic [3:0]  res;
        logic        fnd;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [19:0] pk(input logic [3:0] a, b, c, d, e);
        return {e, d, c, b, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called #1 after an edge; returns observed guess sequence and edges until done.
    task automatic run_search(input logic [3:0] tgt, output logic [19:0] seq, output int cycles);
        int n;
        target = tgt;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        seq = '0;
        seq[3:0] = bus.guess;
        n = 1;
        cycles = 0;
        while (!bus.done && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
            if (!bus.done && n < 5) begin
                seq[n*4 +: 4] = bus.guess;
                n++;
            end
        end
        if (!bus.done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [19:0] seq;
        int cyc;

        vecs[0] = '{4'd10, pk(8, 12, 10, 0, 0), 3, 4'd10, 1'b1};
        vecs[1] = '{4'd0,  pk(8, 4, 2, 1, 0),   5, 4'd0,  1'b1};
        vecs[2] = '{4'd15, pk(8, 12, 14, 15, 0), 4, 4'd15, 1'b1};
        vecs[3] = '{4'd1,  pk(8, 4, 2, 1, 0),   4, 4'd1,  1'b1};
        vecs[4] = '{4'd6,  pk(8, 4, 6, 0, 0),   3, 4'd6,  1'b1};
        vecs[5] = '{4'd5,  pk(8, 4, 6, 5, 0),   4, 4'd5,  1'b1};
        vecs[6] = '{4'd9,  pk(8, 12, 10, 9, 0), 4, 4'd9,  1'b1};
        vecs[7] = '{4'd12, pk(8, 12, 0, 0, 0),  2, 4'd12, 1'b1};
        vecs[8] = '{4'd8,  pk(8, 0, 0, 0, 0),   1, 4'd8,  1'b1};

        bus.start = 1'b0;
        #1;
        chk("rst_guess", bus.guess, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_found", bus.found, 0);
        chk("rst_err", bus.err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", bus.busy, 0);

        foreach (vecs[i]) begin
            run_search(vecs[i].tgt, seq, cyc);
            chk($sformatf("seq_t%0d", vecs[i].tgt), seq, vecs[i].seq);
            chk($sformatf("lat_t%0d", vecs[i].tgt), cyc, vecs[i].cycles);
            chk($sformatf("res_t%0d", vecs[i].tgt), bus.result, vecs[i].res);
            chk($sformatf("fnd_t%0d", vecs[i].tgt), bus.found, vecs[i].fnd);
            chk($sformatf("err_t%0d", vecs[i].tgt), bus.err, 0);
            chk($sformatf("busy_t%0d", vecs[i].tgt), bus.busy, 0);
            @(posedge clk); #1;
            chk($sformatf("pulse_t%0d", vecs[i].tgt), bus.done, 0);
            chk($sformatf("hold_t%0d", vecs[i].tgt), bus.result, vecs[i].res);
            chk($sformatf("ghold_t%0d", vecs[i].tgt), bus.guess, vecs[i].res);
        end

        // Asynchronous reset in the second SEARCH cycle.
        target = 4'd10;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("mid_busy", bus.busy, 1);
        @(posedge clk); #1;
        chk("mid_guess", bus.guess, 12);
        rst = 1'b1;
        #1;
        chk("arst_guess", bus.guess, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_result", bus.result, 0);
        chk("arst_found", bus.found, 0);
        chk("arst_done", bus.done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("arst_nodone", bus.done, 0);
        end
        run_search(4'd6, seq, cyc);
        chk("post_rst_res", bus.result, 6);
        chk("post_rst_fnd", bus.found, 1);
        @(posedge clk); #1;

        // start held high: done every 5th edge, no restart while busy.
        target = 4'd5;
        bus.start = 1'b1;
        @(posedge clk); #1;
        chk("bb_g0", bus.guess, 8);
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bb_done%0d", k), bus.done, (k % 5) == 4);
            if (k == 1) chk("bb_g1", bus.guess, 4);
            if (k == 2) chk("bb_g2", bus.guess, 6);
            if (k == 3) chk("bb_g3", bus.guess, 5);
            if ((k % 5) == 4) chk($sformatf("bb_res%0d", k), bus.result, 5);
        end
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Contradictory comparator flags in the second SEARCH cycle.
        target = 4'd10;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("oh_guess", bus.guess, 12);
        force_both = 1'b1;
        @(posedge clk); #1;
        force_both = 1'b0;
`ifdef CMP_ONEHOT_CHECK_EN
        chk("oh_done", bus.done, 1);
        chk("oh_err", bus.err, 1);
        chk("oh_found", bus.found, 0);
        chk("oh_result", bus.result, 12);
        @(posedge clk); #1;
        chk("oh_err_hold", bus.err, 1);
        run_search(4'd3, seq, cyc);
        chk("oh_err_clr", bus.err, 0);
        chk("oh_res2", bus.result, 3);
`else
        chk("oh_nodone", bus.done, 0);
        chk("oh_guess2", bus.guess, 10);
        @(posedge clk); #1;
        chk("oh_done", bus.done, 1);
        chk("oh_result", bus.result, 10);
        chk("oh_found", bus.found, 1);
        chk("oh_err", bus.err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
